// File: rtl/even_count_checker.sv
// rtl/even_count_checker.sv - sequence checker for an upstream even up-counter
// Tracks q against q_prev+2 and reports matches, legal wraps and sticky errors.
module even_count_checker #(
    parameter int CNT_W = 8,
    parameter int ERR_W = 4
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             en,
    input  logic [CNT_W-1:0] q,
    input  logic [CNT_W-1:0] cmp_val,
    input  logic             clr_err,
    output logic             locked,
    output logic             match,
    output logic             wrap,
    output logic [7:0]       wrap_cnt,
    output logic             err,
    output logic [ERR_W-1:0] err_cnt
);

    typedef enum logic [1:0] {
        ST_IDLE  = 2'd0,
        ST_TRACK = 2'd1,
        ST_FAULT = 2'd2
    } state_t;

    localparam logic [CNT_W-1:0] WRAP_FROM = {{(CNT_W-1){1'b1}}, 1'b0};
    localparam logic [ERR_W-1:0] ERR_MAX   = '1;
    localparam logic [7:0]       WRAP_MAX  = 8'hFF;

    state_t           r_state;
    logic [CNT_W-1:0] r_q_prev;
    logic             r_locked;
    logic             r_match;
    logic             r_wrap;
    logic [7:0]       r_wrap_cnt;
    logic             r_err;
    logic [ERR_W-1:0] r_err_cnt;

    logic [CNT_W-1:0] w_expect;
    logic             w_seq_err;
    logic             w_wrap;

    assign w_expect  = r_q_prev + CNT_W'(2);
    // Only TRACK has a valid reference; elsewhere an odd value is the sole error.
    assign w_seq_err = q[0] || ((r_state == ST_TRACK) && (q != w_expect));
    assign w_wrap    = (r_state == ST_TRACK) && (r_q_prev == WRAP_FROM) && (q == '0);

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            r_state    <= ST_IDLE;
            r_q_prev   <= '0;
            r_locked   <= 1'b0;
            r_match    <= 1'b0;
            r_wrap     <= 1'b0;
            r_wrap_cnt <= '0;
            r_err      <= 1'b0;
            r_err_cnt  <= '0;
        end else begin
            r_match <= 1'b0;
            r_wrap  <= 1'b0;
            if (en) begin
                r_q_prev <= q;
                r_match  <= (q == cmp_val);
            end
            if (clr_err) begin
                r_err     <= 1'b0;
                r_err_cnt <= '0;
                r_state   <= ST_IDLE;
                r_locked  <= 1'b0;
            end else if (!en) begin
                r_state  <= ST_IDLE;
                r_locked <= 1'b0;
            end else if (w_seq_err) begin
                r_err    <= 1'b1;
                if (r_err_cnt != ERR_MAX) begin
                    r_err_cnt <= r_err_cnt + ERR_W'(1);
                end
                r_state  <= ST_FAULT;
                r_locked <= 1'b0;
            end else begin
                case (r_state)
                    ST_IDLE: begin
                        r_state  <= ST_TRACK;
                        r_locked <= 1'b1;
                    end
                    ST_TRACK: begin
                        r_locked <= 1'b1;
                        if (w_wrap) begin
                            r_wrap <= 1'b1;
                            if (r_wrap_cnt != WRAP_MAX) begin
                                r_wrap_cnt <= r_wrap_cnt + 8'd1;
                            end
                        end
                    end
                    ST_FAULT: begin
                        r_locked <= 1'b0;
                    end
                    default: begin
                        r_state  <= ST_IDLE;
                        r_locked <= 1'b0;
                    end
                endcase
            end
        end
    end

    assign locked   = r_locked;
    assign match    = r_match;
    assign wrap     = r_wrap;
    assign wrap_cnt = r_wrap_cnt;
    assign err      = r_err;
    assign err_cnt  = r_err_cnt;

endmodule

// File: tb/tb_even_count_checker.sv
// tb/tb_even_count_checker.sv - directed self-checking bench for even_count_checker
module tb_even_count_checker;

    logic       clk = 1'b0;
    logic       reset = 1'b1;
    logic       en = 1'b0;
    logic [7:0] q = 8'd0;
    logic [7:0] cmp_val = 8'd255;
    logic       clr_err = 1'b0;
    logic       locked;
    logic       match;
    logic       wrap;
    logic [7:0] wrap_cnt;
    logic       err;
    logic [3:0] err_cnt;

    int total = 0;
    int bad   = 0;

    even_count_checker #(.CNT_W(8), .ERR_W(4)) dut (
        .clk      (clk),
        .reset    (reset),
        .en       (en),
        .q        (q),
        .cmp_val  (cmp_val),
        .clr_err  (clr_err),
        .locked   (locked),
        .match    (match),
        .wrap     (wrap),
        .wrap_cnt (wrap_cnt),
        .err      (err),
        .err_cnt  (err_cnt)
    );

    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        total++;
        assert (obs === exp) else begin
            bad++;
            $error("FAIL %s observed=%0d expected=%0d", tag, obs, exp);
        end
    endtask

    task automatic step(input logic e, input logic [7:0] v, input logic c);
        en      = e;
        q       = v;
        clr_err = c;
        @(posedge clk);
        #1;
    endtask

    task automatic check_all_zero(input string tag);
        check({tag, "_locked"},   32'(locked),   32'd0);
        check({tag, "_match"},    32'(match),    32'd0);
        check({tag, "_wrap"},     32'(wrap),     32'd0);
        check({tag, "_wrap_cnt"}, 32'(wrap_cnt), 32'd0);
        check({tag, "_err"},      32'(err),      32'd0);
        check({tag, "_err_cnt"},  32'(err_cnt),  32'd0);
    endtask

    initial begin
        #1 reset = 1'b0;
        #1 check_all_zero("reset");
        @(posedge clk);
        #1 reset = 1'b1;

        step(1'b1, 8'd0, 1'b0);
        check("lock_first_even", 32'(locked), 32'd1);
        check("err_first_even",  32'(err),    32'd0);
        step(1'b1, 8'd2, 1'b0);
        check("lock_q2", 32'(locked), 32'd1);
        step(1'b1, 8'd4, 1'b0);
        step(1'b1, 8'd6, 1'b0);
        check("lock_q6", 32'(locked), 32'd1);
        check("err_q6",  32'(err),    32'd0);

        for (int v = 8; v <= 250; v += 2) step(1'b1, 8'(v), 1'b0);
        check("sweep_err",    32'(err),      32'd0);
        check("sweep_locked", 32'(locked),   32'd1);
        check("sweep_wrapc",  32'(wrap_cnt), 32'd0);

        step(1'b1, 8'd252, 1'b0);
        step(1'b1, 8'd254, 1'b0);
        check("wrap_pre", 32'(wrap), 32'd0);
        step(1'b1, 8'd0, 1'b0);
        check("wrap_pulse", 32'(wrap),     32'd1);
        check("wrap_cnt1",  32'(wrap_cnt), 32'd1);
        step(1'b1, 8'd2, 1'b0);
        check("wrap_post",     32'(wrap),     32'd0);
        check("wrap_cnt_hold", 32'(wrap_cnt), 32'd1);
        check("wrap_err",      32'(err),      32'd0);

        for (int v = 4; v <= 12; v += 2) step(1'b1, 8'(v), 1'b0);
        check("pre_odd_err", 32'(err), 32'd0);
        step(1'b1, 8'd15, 1'b0);
        check("odd_err",     32'(err),     32'd1);
        check("odd_err_cnt", 32'(err_cnt), 32'd1);
        check("odd_locked",  32'(locked),  32'd0);
        step(1'b1, 8'd17, 1'b0);
        check("fault_err_cnt2", 32'(err_cnt), 32'd2);

        step(1'b1, 8'd20, 1'b1);
        check("clr_err",     32'(err),     32'd0);
        check("clr_err_cnt", 32'(err_cnt), 32'd0);
        check("clr_locked",  32'(locked),  32'd0);
        step(1'b1, 8'd22, 1'b0);
        check("relock", 32'(locked), 32'd1);
        check("relock_err", 32'(err), 32'd0);

        cmp_val = 8'd100;
        for (int v = 24; v <= 94; v += 2) step(1'b1, 8'(v), 1'b0);
        for (int v = 96; v <= 104; v += 2) begin
            step(1'b1, 8'(v), 1'b0);
            check($sformatf("match_q%0d", v), 32'(match), (v == 100) ? 32'd1 : 32'd0);
        end
        step(1'b1, 8'd106, 1'b0);
        check("match_after", 32'(match), 32'd0);

        cmp_val = 8'd107;
        step(1'b1, 8'd107, 1'b0);
        check("match_odd",     32'(match),   32'd1);
        check("odd107_err",    32'(err),     32'd1);
        check("odd107_errcnt", 32'(err_cnt), 32'd1);

        step(1'b0, 8'd107, 1'b0);
        check("dis_match",    32'(match),    32'd0);
        check("dis_locked",   32'(locked),   32'd0);
        check("dis_err",      32'(err),      32'd1);
        check("dis_err_cnt",  32'(err_cnt),  32'd1);
        check("dis_wrap_cnt", 32'(wrap_cnt), 32'd1);

        for (int i = 0; i < 20; i++) step(1'b1, 8'(2 * i + 1), 1'b0);
        check("sat_err_cnt", 32'(err_cnt), 32'd15);
        step(1'b1, 8'd201, 1'b0);
        check("sat_hold", 32'(err_cnt), 32'd15);

        step(1'b1, 8'd0, 1'b1);
        check("clr2_err_cnt", 32'(err_cnt), 32'd0);
        step(1'b1, 8'd1, 1'b0);
        step(1'b1, 8'd3, 1'b0);
        step(1'b1, 8'd5, 1'b0);
        check("build_cnt3", 32'(err_cnt), 32'd3);
        step(1'b0, 8'd5, 1'b0);
        step(1'b1, 8'd40, 1'b0);
        check("idle_relock",   32'(locked),  32'd1);
        check("idle_keep_cnt", 32'(err_cnt), 32'd3);
        step(1'b1, 8'd42, 1'b0);
        check("track_again", 32'(locked), 32'd1);

        #2 reset = 1'b0;
        #1 check_all_zero("async_rst");
        #2 reset = 1'b1;

        step(1'b1, 8'd44, 1'b0);
        check("post_rst_lock", 32'(locked), 32'd1);
        check("post_rst_err",  32'(err),    32'd0);
        step(1'b1, 8'd46, 1'b0);
        check("post_rst_track", 32'(locked), 32'd1);
        step(1'b1, 8'd50, 1'b0);
        check("skip_err",     32'(err),     32'd1);
        check("skip_err_cnt", 32'(err_cnt), 32'd1);
        check("skip_locked",  32'(locked),  32'd0);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
